// File: rtl/vga_text_render.sv
// vga_text_render: three-stage 80x30 text-mode pixel pipeline.
// Stage 0 forms the text RAM address, stage 1 forms the font ROM address,
// stage 2 picks the font bit and maps the attribute colour to RGB.
// Optional hardware cursor compiled in with `define VGA_TEXT_CURSOR_EN.
`timescale 1ns/1ps

module vga_text_render (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        de,
    input  logic        frame,
    input  logic [6:0]  cursor_x,
    input  logic [4:0]  cursor_y,
    output logic [11:0] text_addr,
    input  logic [15:0] text_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b
);

    // CGA 16-colour palette; index 6 is brown rather than dark yellow.
    function automatic logic [11:0] palette_rgb(input logic [3:0] idx);
        logic [3:0] r_v;
        logic [3:0] g_v;
        logic [3:0] b_v;
        logic [3:0] hi_v;
        hi_v = idx[3] ? 4'h5 : 4'h0;
        r_v  = (idx[2] ? 4'hA : 4'h0) + hi_v;
        g_v  = (idx[1] ? 4'hA : 4'h0) + hi_v;
        b_v  = (idx[0] ? 4'hA : 4'h0) + hi_v;
        if (idx == 4'd6) begin
            g_v = 4'h5;
        end else begin
            g_v = g_v;
        end
        return {r_v, g_v, b_v};
    endfunction

    logic [6:0]  col_s;
    logic [4:0]  row_s;
    logic [11:0] cell_addr_s;

    logic [4:0]  blink_cnt_r;

    logic [11:0] text_addr_r;
    logic [2:0]  xlo_s0_r;
    logic [3:0]  scan_s0_r;
    logic        de_s0_r;
    logic        phase_s0_r;

    logic [11:0] font_addr_r;
    logic [7:0]  attr_s1_r;
    logic [2:0]  xlo_s1_r;
    logic        de_s1_r;
    logic        phase_s1_r;

    logic        font_bit_s;
    logic        cursor_hit_s;
    logic        fg_on_s;
    logic [11:0] color_s;
    logic [11:0] rgb_r;
    logic        unused_s;

    assign col_s       = x[9:3];
    assign row_s       = y[8:4];
    // row*80 = row*64 + row*16; max 29*80+79 = 2399 fits in 12 bits.
    assign cell_addr_s = {1'b0, row_s, 6'b0} + {3'b0, row_s, 4'b0} + {5'b0, col_s};

    // Blink counter advances once per frame; bit 4 is the blink phase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_r <= 5'd0;
        end else if (frame) begin
            blink_cnt_r <= blink_cnt_r + 5'd1;
        end else begin
            blink_cnt_r <= blink_cnt_r;
        end
    end

    // Stage 0: text address plus the pixel context that travels with it.
    // The phase is captured here so a frame pulse only affects later pixels.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            text_addr_r <= 12'd0;
            xlo_s0_r    <= 3'd0;
            scan_s0_r   <= 4'd0;
            de_s0_r     <= 1'b0;
            phase_s0_r  <= 1'b0;
        end else begin
            text_addr_r <= cell_addr_s;
            xlo_s0_r    <= x[2:0];
            scan_s0_r   <= y[3:0];
            de_s0_r     <= de;
            phase_s0_r  <= blink_cnt_r[4];
        end
    end

    // Stage 1: font address from the character code; attribute delayed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            font_addr_r <= 12'd0;
            attr_s1_r   <= 8'd0;
            xlo_s1_r    <= 3'd0;
            de_s1_r     <= 1'b0;
            phase_s1_r  <= 1'b0;
        end else begin
            font_addr_r <= {text_data[7:0], scan_s0_r};
            attr_s1_r   <= text_data[15:8];
            xlo_s1_r    <= xlo_s0_r;
            de_s1_r     <= de_s0_r;
            phase_s1_r  <= phase_s0_r;
        end
    end

`ifdef VGA_TEXT_CURSOR_EN
    logic [6:0] col_s0_r;
    logic [4:0] row_s0_r;
    logic [6:0] col_s1_r;
    logic [4:0] row_s1_r;
    logic [3:0] scan_s1_r;

    // Cell position and scanline delayed for the cursor compare.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_s0_r  <= 7'd0;
            row_s0_r  <= 5'd0;
            col_s1_r  <= 7'd0;
            row_s1_r  <= 5'd0;
            scan_s1_r <= 4'd0;
        end else begin
            col_s0_r  <= col_s;
            row_s0_r  <= row_s;
            col_s1_r  <= col_s0_r;
            row_s1_r  <= row_s0_r;
            scan_s1_r <= scan_s0_r;
        end
    end

    // Underline cursor on the bottom two scanlines, visible in phase 0.
    assign cursor_hit_s = ~phase_s1_r & (col_s1_r == cursor_x) &
                          (row_s1_r == cursor_y) & (scan_s1_r[3:1] == 3'b111);
    assign unused_s     = y[9];
`else
    assign cursor_hit_s = 1'b0;
    assign unused_s     = ^{y[9], cursor_x, cursor_y};
`endif

    // Stage 2 colour select: font bit, blink masking, cursor, blanking.
    always_comb begin
        font_bit_s = font_data[3'd7 - xlo_s1_r];
        fg_on_s    = (font_bit_s & ~(attr_s1_r[7] & phase_s1_r)) | cursor_hit_s;
        color_s    = 12'h000;
        if (!de_s1_r) begin
            color_s = 12'h000;
        end else if (fg_on_s) begin
            color_s = palette_rgb(attr_s1_r[3:0]);
        end else begin
            color_s = palette_rgb({1'b0, attr_s1_r[6:4]});
        end
    end

    // Stage 2: registered pixel colour.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rgb_r <= 12'h000;
        end else begin
            rgb_r <= color_s;
        end
    end

    assign text_addr = text_addr_r;
    assign font_addr = font_addr_r;
    assign r         = rgb_r[11:8];
    assign g         = rgb_r[7:4];
    assign b         = rgb_r[3:0];

endmodule

// File: tb/tb_vga_text_render.sv
// tb_vga_text_render: directed vectors for vga_text_render with
// combinational behavioural text RAM / font ROM models.
`timescale 1ns/1ps

module tb_vga_text_render;

    logic        clock;
    logic        reset_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de;
    logic        frame;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic [11:0] text_addr;
    logic [15:0] text_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic [11:0] rgb_s;

    logic [15:0] text_mem [0:4095];
    logic [7:0]  font_mem [0:4095];

    int vec_cnt;
    int err_cnt;

    vga_text_render dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .x         (x),
        .y         (y),
        .de        (de),
        .frame     (frame),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .text_addr (text_addr),
        .text_data (text_data),
        .font_addr (font_addr),
        .font_data (font_data),
        .r         (r),
        .g         (g),
        .b         (b)
    );

    assign text_data = text_mem[text_addr];
    assign font_data = font_mem[font_addr];
    assign rgb_s     = {r, g, b};

    // 25 MHz pixel clock.
    initial clock = 1'b0;
    always #20 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int xv, input int yv, input logic dev);
        x  = xv[9:0];
        y  = yv[9:0];
        de = dev;
    endtask

    // Hold one pixel long enough for it to fill the whole pipeline.
    task automatic hold_px(input int xv, input int yv, input logic dev);
        drive(xv, yv, dev);
        repeat (3) step();
    endtask

    task automatic frame_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            de    = 1'b0;
            frame = 1'b1;
            step();
            frame = 1'b0;
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        for (int i = 0; i < 4096; i++) begin
            text_mem[i] = 16'h0000;
            font_mem[i] = 8'h00;
        end
        text_mem[162]  = 16'h1E41;  // row 2 col 2
        font_mem[12'h413] = 8'h80;
        text_mem[2399] = 16'h0C52;  // row 29 col 79
        font_mem[12'h52F] = 8'h01;
        text_mem[80]   = 16'h6020;  // row 1 col 0, bg brown
        text_mem[81]   = 16'h7830;  // row 1 col 1, fg 8 / bg 7
        font_mem[12'h300] = 8'h0F;
        text_mem[5]    = 16'h0700;  // cursor cell
        text_mem[0]    = 16'h9F41;  // blinking cell
        font_mem[12'h410] = 8'hFF;

        reset_n  = 1'b0;
        frame    = 1'b0;
        cursor_x = 7'd5;
        cursor_y = 5'd0;
        drive(17, 35, 1'b1);

        // Reset state.
        step();
        step();
        check("rst_text_addr", {20'd0, text_addr}, 32'd0);
        check("rst_font_addr", {20'd0, font_addr}, 32'd0);
        check("rst_rgb", {20'd0, rgb_s}, 32'd0);

        // Address arithmetic and first pixels through the pipe.
        reset_n = 1'b1;
        step();
        check("text_addr_162", {20'd0, text_addr}, 32'd162);
        step();
        check("font_addr_413", {20'd0, font_addr}, 32'h413);
        step();
        check("blue_x1", {20'd0, rgb_s}, 32'h00A);
        hold_px(16, 35, 1'b1);
        check("yellow_x0", {20'd0, rgb_s}, 32'hFF5);

        // Exact three-clock latency on a two-pixel burst.
        hold_px(16, 35, 1'b0);
        drive(16, 35, 1'b1);
        step();
        check("lat_e1", {20'd0, rgb_s}, 32'h000);
        drive(17, 35, 1'b1);
        step();
        check("lat_e2", {20'd0, rgb_s}, 32'h000);
        de = 1'b0;
        step();
        check("lat_e3", {20'd0, rgb_s}, 32'hFF5);
        step();
        check("lat_e4", {20'd0, rgb_s}, 32'h00A);
        step();
        check("lat_e5", {20'd0, rgb_s}, 32'h000);

        // Bottom-right cell and palette corners.
        hold_px(639, 479, 1'b1);
        check("last_text_addr", {20'd0, text_addr}, 32'd2399);
        check("last_font_addr", {20'd0, font_addr}, 32'h52F);
        check("last_px_on", {20'd0, rgb_s}, 32'hF55);
        hold_px(632, 479, 1'b1);
        check("last_px_off", {20'd0, rgb_s}, 32'h000);
        hold_px(0, 16, 1'b1);
        check("pal_brown", {20'd0, rgb_s}, 32'hA50);
        hold_px(12, 16, 1'b1);
        check("pal_grey8", {20'd0, rgb_s}, 32'h555);
        hold_px(11, 16, 1'b1);
        check("pal_grey7", {20'd0, rgb_s}, 32'hAAA);

        // Blanking with valid memory contents.
        hold_px(16, 35, 1'b0);
        check("de_low", {20'd0, rgb_s}, 32'h000);

        // Cursor on scanline 14 of cell (5,0).
        for (int xi = 40; xi < 48; xi++) begin
            hold_px(xi, 14, 1'b1);
`ifdef VGA_TEXT_CURSOR_EN
            check("cursor_px", {20'd0, rgb_s}, 32'hAAA);
`else
            check("cursor_px", {20'd0, rgb_s}, 32'h000);
`endif
        end

        // Blink: visible in phase 0, frame pulse affects only later pixels.
        hold_px(0, 0, 1'b1);
        check("blink_fg0", {20'd0, rgb_s}, 32'hFFF);
        frame_pulse(15);
        drive(0, 0, 1'b1);
        frame = 1'b1;
        step();
        frame = 1'b0;
        drive(1, 0, 1'b1);
        step();
        de = 1'b0;
        step();
        check("frame_old_px", {20'd0, rgb_s}, 32'hFFF);
        step();
        check("frame_new_px", {20'd0, rgb_s}, 32'h00A);
        for (int xi = 0; xi < 8; xi++) begin
            hold_px(xi, 0, 1'b1);
            check("blink_bg", {20'd0, rgb_s}, 32'h00A);
        end

        // Asynchronous reset mid-line clears outputs and the blink counter.
        hold_px(2, 0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_rgb", {20'd0, rgb_s}, 32'h000);
        check("midrst_text", {20'd0, text_addr}, 32'd0);
        check("midrst_font", {20'd0, font_addr}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_e1", {20'd0, rgb_s}, 32'h000);
        step();
        check("post_rst_e2", {20'd0, rgb_s}, 32'h000);
        step();
        check("post_rst_e3", {20'd0, rgb_s}, 32'hFFF);

        // Counter 16 hides, counter 32 wraps to 0 and shows again.
        frame_pulse(16);
        hold_px(5, 0, 1'b1);
        check("cnt16_bg", {20'd0, rgb_s}, 32'h00A);
        frame_pulse(16);
        hold_px(5, 0, 1'b1);
        check("cnt32_fg", {20'd0, rgb_s}, 32'hFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
